// File: rtl/sync_flywheel.sv
// Sync flywheel: checks and locks to a periodic input sync, then regenerates a clean one.
// Optional SYNC_FLYWHEEL_REALIGN_EN re-phases to an off-time sync while locked.
module sync_flywheel #(
  parameter int PERIOD     = 1024,
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        din,
  output logic        dout,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] err_count
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [CW-1:0] CTR_MAX   = CW'(PERIOD - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic        dout_q, dout_d;
  logic        lock_q, lock_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        slot;

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    good_d  = good_q;
    miss_d  = miss_q;
    dout_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    slot    = (ctr_q == CTR_MAX);
    if (ce) begin
      ctr_d = slot ? '0 : ctr_q + 1'b1;
      unique case (state_q)
        UNLOCKED: begin
          if (din) begin
            ctr_d   = '0;
            good_d  = GW'(1);
            state_d = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (din && slot) begin
            good_d = good_q + 1'b1;
            if (good_q == GOOD_LAST) begin
              state_d = LOCKED;
              miss_d  = '0;
              dout_d  = 1'b1;
            end
          end else if (din) begin
            ctr_d  = '0;
            good_d = GW'(1);
          end else if (slot) begin
            state_d = UNLOCKED;
            good_d  = '0;
          end
        end
        LOCKED: begin
          dout_d = slot;
          if (din && slot) begin
            miss_d = '0;
          end else if (slot) begin
            // the slot that drops lock still emits its dout
            if (miss_q == MISS_LAST) begin
              state_d = UNLOCKED;
              good_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else if (din) begin
            err_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`ifdef SYNC_FLYWHEEL_REALIGN_EN
            ctr_d  = '0;
            miss_d = '0;
`else
            ctr_d  = ctr_d;
`endif
          end
        end
        default: begin
          state_d = UNLOCKED;
          good_d  = '0;
          miss_d  = '0;
        end
      endcase
    end
    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      ctr_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      dout_q  <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      dout_q  <= dout_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout      = dout_q;
  assign locked    = lock_q;
  assign sync_err  = err_q;
  assign err_count = cnt_q;

endmodule
